// File: rtl/mips_pipe_pkg.sv
// Shared pipeline constants, scoreboard entry type and select-width helper
// for the MIPS hazard scoreboard.
package mips_pipe_pkg;

    localparam int unsigned STAGE_EX  = 1;
    localparam int unsigned STAGE_MEM = 2;
    localparam int unsigned STAGE_WB  = 3;

    // Widest register address the scoreboard can hold; narrower addresses are zero-extended
    localparam int unsigned SB_DEST_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [SB_DEST_W-1:0] dest;
        logic                 load;
    } sb_entry_t;

    // Width of a forwarding select able to name entries 0..num_stages
    function automatic int unsigned fwd_sel_w(input int unsigned num_stages);
        return $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against every scoreboard entry.
// HAZARD_FWD_EN adds the nearest-match index used as the forwarding select.
module hazard_match
    import mips_pipe_pkg::*;
#(
    parameter int unsigned NUM_STAGES   = 3,
`ifdef HAZARD_FWD_EN
    parameter int unsigned SEL_W        = 2,
`endif
    parameter bit          EXCLUDE_LAST = 1'b0
) (
    input  logic                                 src_used,
    input  logic [SB_DEST_W-1:0]                 src,
    input  logic [NUM_STAGES:1]                  ent_valid,
    input  logic [NUM_STAGES:1][SB_DEST_W-1:0]   ent_dest,
`ifdef HAZARD_FWD_EN
    output logic [SEL_W-1:0]                     nearest,
`endif
    output logic [NUM_STAGES:1]                  match_vec
);

    // Per-entry match; the oldest entry is ignored when the register file is write-first
    always_comb begin
        match_vec = '0;
        for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
            match_vec[k] = src_used && ent_valid[k] && (ent_dest[k] == src)
                           && !(EXCLUDE_LAST && (k == NUM_STAGES));
        end
    end

`ifdef HAZARD_FWD_EN
    // Youngest producer wins: scan oldest to youngest so the smallest index is kept
    always_comb begin
        nearest = '0;
        for (int k = int'(NUM_STAGES); k >= 1; k--) begin
            if (match_vec[k]) begin
                nearest = SEL_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/mips_hazard_scoreboard.sv
// Hazard and redirect controller for the 5-stage MIPS pipeline.
// Shift-register scoreboard of destinations past ID drives stall/flush enables.
// Build option: HAZARD_FWD_EN enables forwarding selects and limits stalls to load-use.
module mips_hazard_scoreboard
    import mips_pipe_pkg::*;
#(
    parameter int unsigned  NUM_STAGES     = STAGE_WB,
    parameter int unsigned  REG_ADDR_W     = 5,
    parameter bit           WB_BYPASS      = 1'b0,
    parameter int unsigned  REDIRECT_STAGE = STAGE_WB,
    parameter int unsigned  CNT_W          = 16,
    localparam int unsigned SEL_W          = fwd_sel_w(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  redirect,
    output logic                  hold_pc,
    output logic                  hold_if_id,
    output logic                  bubble_id_ex,
    output logic [NUM_STAGES:0]   flush,
    output logic [SEL_W-1:0]      fwd_rs_sel,
    output logic [SEL_W-1:0]      fwd_rt_sel,
    output logic [CNT_W-1:0]      stall_count
);

    sb_entry_t [NUM_STAGES:1]               sb_q, sb_d;
    logic [CNT_W-1:0]                       stall_count_q, stall_count_d;
    logic [NUM_STAGES:1]                    ent_valid;
    logic [NUM_STAGES:1][SB_DEST_W-1:0]     ent_dest;
    logic [NUM_STAGES:1]                    rs_match, rt_match;
    logic                                   stall_c;
    logic                                   stall_eff_c;
    logic                                   unused_load;

    // Split the scoreboard into the fields the comparators need
    always_comb begin
        ent_valid = '0;
        ent_dest  = '0;
        for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
            ent_valid[k] = sb_q[k].valid;
            ent_dest[k]  = sb_q[k].dest;
        end
    end

    // Load flags of entries that can never cause a load-use stall are sunk here
    always_comb begin
        unused_load = 1'b0;
        for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
            unused_load = unused_load ^ sb_q[k].load;
        end
    end

`ifdef HAZARD_FWD_EN
    logic [SEL_W-1:0]    rs_nearest, rt_nearest;
    logic [NUM_STAGES:1] fwd_ok;
`endif

    hazard_match #(
        .NUM_STAGES   (NUM_STAGES),
`ifdef HAZARD_FWD_EN
        .SEL_W        (SEL_W),
`endif
        .EXCLUDE_LAST (WB_BYPASS)
    ) u_rs_match (
        .src_used  (id_valid && id_rs_used),
        .src       (SB_DEST_W'(id_rs)),
        .ent_valid (ent_valid),
        .ent_dest  (ent_dest),
`ifdef HAZARD_FWD_EN
        .nearest   (rs_nearest),
`endif
        .match_vec (rs_match)
    );

    hazard_match #(
        .NUM_STAGES   (NUM_STAGES),
`ifdef HAZARD_FWD_EN
        .SEL_W        (SEL_W),
`endif
        .EXCLUDE_LAST (WB_BYPASS)
    ) u_rt_match (
        .src_used  (id_valid && id_rt_used),
        .src       (SB_DEST_W'(id_rt)),
        .ent_valid (ent_valid),
        .ent_dest  (ent_dest),
`ifdef HAZARD_FWD_EN
        .nearest   (rt_nearest),
`endif
        .match_vec (rt_match)
    );

`ifdef HAZARD_FWD_EN
    // A result is forwardable from every entry except a load still in EX
    always_comb begin
        fwd_ok = '1;
        for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
            fwd_ok[k] = !((k == STAGE_EX) && sb_q[k].load);
        end
    end

    // Only the nearest match can be non-forwardable, so any such match means load-use
    always_comb begin
        stall_c    = (|(rs_match & ~fwd_ok)) || (|(rt_match & ~fwd_ok));
        fwd_rs_sel = rs_nearest;
        fwd_rt_sel = rt_nearest;
    end
`else
    // Without forwarding every RAW hazard stalls
    always_comb begin
        stall_c    = (|rs_match) || (|rt_match);
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
    end
`endif

    // Redirect overrides stall: flush younger stages and release the holds
    always_comb begin
        stall_eff_c  = stall_c && !redirect;
        hold_pc      = stall_eff_c;
        hold_if_id   = stall_eff_c;
        bubble_id_ex = stall_eff_c;
        flush        = '0;
        for (int unsigned k = 0; k <= NUM_STAGES; k++) begin
            flush[k] = redirect && (k < REDIRECT_STAGE);
        end
        stall_count  = stall_count_q;
    end

    // Scoreboard shift, entry-1 load and saturating stall counter
    always_comb begin
        sb_d = '0;
        for (int unsigned k = 2; k <= NUM_STAGES; k++) begin
            sb_d[k] = sb_q[k-1];
        end
        if (id_valid && id_reg_write && (id_dest != '0) && !stall_eff_c) begin
            sb_d[1].valid = 1'b1;
            sb_d[1].dest  = SB_DEST_W'(id_dest);
            sb_d[1].load  = id_mem_read;
        end
        if (redirect) begin
            for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
                if (k < REDIRECT_STAGE) begin
                    sb_d[k] = '0;
                end
            end
        end
        stall_count_d = stall_count_q;
        if (stall_eff_c && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_q          <= '0;
            stall_count_q <= '0;
        end else begin
            sb_q          <= sb_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Self-checking bench for mips_hazard_scoreboard: directed scenarios plus
// random traffic against an in-flight-instruction list model.
module tb_mips_hazard_scoreboard;

    localparam int N     = 3;
    localparam int R     = 3;
    localparam bit WBB   = 1'b0;
    localparam int SAT_W = 3;
    localparam int SAT_MAX = (1 << SAT_W) - 1;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int PAIR_STALLS = FWD ? 0 : 3;
    localparam int LW_STALLS   = FWD ? 1 : 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_rs_used, id_rt_used, id_reg_write, id_mem_read, redirect;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       hold_pc, hold_if_id, bubble_id_ex;
    logic [3:0] flush;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
    logic [15:0] stall_count;
    logic       s_hold_pc, s_hold_if_id, s_bubble_id_ex;
    logic [3:0] s_flush;
    logic [1:0] s_fwd_rs_sel, s_fwd_rt_sel;
    logic [SAT_W-1:0] s_stall_count;

    always #5 clk = ~clk;

    mips_hazard_scoreboard #(
        .NUM_STAGES(N), .REG_ADDR_W(5), .WB_BYPASS(WBB), .REDIRECT_STAGE(R), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .redirect(redirect),
        .hold_pc(hold_pc), .hold_if_id(hold_if_id), .bubble_id_ex(bubble_id_ex),
        .flush(flush), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .stall_count(stall_count)
    );

    // Narrow-counter copy on the same inputs to reach saturation quickly
    mips_hazard_scoreboard #(
        .NUM_STAGES(N), .REG_ADDR_W(5), .WB_BYPASS(WBB), .REDIRECT_STAGE(R), .CNT_W(SAT_W)
    ) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .redirect(redirect),
        .hold_pc(s_hold_pc), .hold_if_id(s_hold_if_id), .bubble_id_ex(s_bubble_id_ex),
        .flush(s_flush), .fwd_rs_sel(s_fwd_rs_sel), .fwd_rt_sel(s_fwd_rt_sel),
        .stall_count(s_stall_count)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: list of register-writing instructions past ID, tagged with their stage
    typedef struct {
        int stage;
        int dest;
        bit load;
    } inflight_t;

    inflight_t fl[$];
    int        m_cnt = 0;
    bit        m_eff = 1'b0;

    function automatic int m_nearest(input int src, input bit used);
        int best = 0;
        if (!used || src == 0) return 0;
        foreach (fl[i]) begin
            if (fl[i].dest == src && !(WBB && fl[i].stage == N) &&
                (best == 0 || fl[i].stage < best))
                best = fl[i].stage;
        end
        return best;
    endfunction

    function automatic bit m_load_at(input int st);
        foreach (fl[i]) if (fl[i].stage == st) return fl[i].load;
        return 1'b0;
    endfunction

    task automatic drive(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                         input int dst, input bit rw, input bit ld, input bit rd);
        id_valid = v;  id_rs = 5'(rs); id_rs_used = rsu; id_rt = 5'(rt); id_rt_used = rtu;
        id_dest = 5'(dst); id_reg_write = rw; id_mem_read = ld; redirect = rd;
    endtask

    // Let inputs settle, then compare every output against the model
    task automatic settle_check(input string tag);
        int rn, tn, exp_flush, sat_exp;
        bit st;
        #1;
        rn = m_nearest(int'(id_rs), id_valid && id_rs_used);
        tn = m_nearest(int'(id_rt), id_valid && id_rt_used);
        st = FWD ? (((rn == 1) || (tn == 1)) && m_load_at(1)) : ((rn != 0) || (tn != 0));
        m_eff = st && !redirect;
        exp_flush = redirect ? ((1 << R) - 1) : 0;
        sat_exp = (m_cnt > SAT_MAX) ? SAT_MAX : m_cnt;
        check({tag, ".hold_pc"},      32'(hold_pc),      32'(m_eff));
        check({tag, ".hold_if_id"},   32'(hold_if_id),   32'(m_eff));
        check({tag, ".bubble"},       32'(bubble_id_ex), 32'(m_eff));
        check({tag, ".flush"},        32'(flush),        32'(exp_flush));
        check({tag, ".fwd_rs"},       32'(fwd_rs_sel),   32'(FWD ? rn : 0));
        check({tag, ".fwd_rt"},       32'(fwd_rt_sel),   32'(FWD ? tn : 0));
        check({tag, ".stall_count"},  32'(stall_count),  32'(m_cnt));
        check({tag, ".s_hold"},       32'(s_hold_pc),    32'(m_eff));
        check({tag, ".s_flush"},      32'(s_flush),      32'(exp_flush));
        check({tag, ".s_count"},      32'(s_stall_count), 32'(sat_exp));
    endtask

    // Clock edge, then age the model and admit the ID instruction
    task automatic advance();
        inflight_t nq[$];
        inflight_t e;
        @(posedge clk);
        foreach (fl[i]) begin
            e = fl[i];
            e.stage++;
            if (e.stage <= N && !(redirect && e.stage < R)) nq.push_back(e);
        end
        if (!m_eff && id_valid && id_reg_write && id_dest != 0 && !(redirect && 1 < R)) begin
            e.stage = 1; e.dest = int'(id_dest); e.load = id_mem_read;
            nq.push_back(e);
        end
        fl = nq;
        if (m_eff && m_cnt < 65535) m_cnt++;
        @(negedge clk);
    endtask

    task automatic step(input string tag);
        settle_check(tag);
        advance();
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step("idle");
    endtask

    // Hold the current ID instruction until it issues; report stall cycles and last rs select
    task automatic run_until_clear(input string tag, output int holds, output int sel);
        bit h;
        holds = 0;
        sel   = 0;
        h     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle_check(tag);
            h   = hold_pc;
            sel = int'(fwd_rs_sel);
            advance();
            if (h) holds++;
            else return;
        end
        check({tag, ".bound"}, 32'(h), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int holds, sel;

        // Reset state with an empty ID
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        check("rst.hold_pc",  32'(hold_pc),      0);
        check("rst.hold_ifid", 32'(hold_if_id),  0);
        check("rst.bubble",   32'(bubble_id_ex), 0);
        check("rst.flush",    32'(flush),        0);
        check("rst.fwd_rs",   32'(fwd_rs_sel),   0);
        check("rst.fwd_rt",   32'(fwd_rt_sel),   0);
        check("rst.count",    32'(stall_count),  0);
        @(negedge clk);
        reset = 1'b0;
        idle(1);

        // add $1 ; add $2,$1,$1
        drive(1, 2, 0, 3, 0, 1, 1, 0, 0);
        step("pair_p");
        drive(1, 1, 1, 1, 1, 2, 1, 0, 0);
        run_until_clear("pair_d", holds, sel);
        check("pair.stalls", 32'(holds), 32'(PAIR_STALLS));
        check("pair.count",  32'(stall_count), 32'(PAIR_STALLS));
        check("pair.sel",    32'(sel), 32'(FWD ? 1 : 0));
        drive(1, 1, 1, 0, 0, 3, 1, 0, 0);
        settle_check("pair_n");
        check("pair_next.sel", 32'(fwd_rs_sel), 32'(FWD ? 2 : 0));
        advance();
        idle(4);

        // lw $1 ; add $3,$1,$0
        drive(1, 2, 1, 0, 0, 1, 1, 1, 0);
        step("lw_p");
        drive(1, 1, 1, 0, 1, 3, 1, 0, 0);
        run_until_clear("lw_d", holds, sel);
        check("lw.stalls", 32'(holds), 32'(LW_STALLS));
        check("lw.sel",    32'(sel), 32'(FWD ? 2 : 0));
        idle(4);

        // Write to $0, then read $0
        drive(1, 1, 0, 2, 0, 0, 1, 1, 0);
        step("zero_p");
        drive(1, 0, 1, 0, 1, 4, 1, 0, 0);
        settle_check("zero_d");
        check("zero.hold",   32'(hold_pc),    0);
        check("zero.fwd_rs", 32'(fwd_rs_sel), 0);
        check("zero.fwd_rt", 32'(fwd_rt_sel), 0);
        advance();
        idle(4);

        // Redirect from WB while the dependent add waits in ID
        drive(1, 2, 0, 3, 0, 1, 1, 0, 0);
        step("redir_p");
        drive(1, 1, 1, 1, 1, 2, 1, 0, 1);
        settle_check("redir_d");
        check("redir.flush", 32'(flush),   32'h7);
        check("redir.hold",  32'(hold_pc), 0);
        advance();
        drive(1, 1, 1, 1, 1, 2, 1, 0, 0);
        settle_check("redir_a");
        check("redir.cleared", 32'(hold_pc), 0);
        advance();
        idle(4);

        // Repeated load-use pairs drive the narrow counter into saturation
        for (int p = 0; p < 10; p++) begin
            drive(1, 2, 1, 0, 0, 1, 1, 1, 0);
            step("sat_p");
            drive(1, 1, 1, 0, 1, 3, 1, 0, 0);
            run_until_clear("sat_d", holds, sel);
        end
        check("sat.narrow", 32'(s_stall_count), 32'(SAT_MAX));
        check("sat.wide",   32'(stall_count),   32'(m_cnt));
        idle(4);

        // Reset asserted in the middle of a stall
        drive(1, 2, 1, 0, 0, 1, 1, 1, 0);
        step("mid_p");
        drive(1, 1, 1, 0, 1, 3, 1, 0, 0);
        settle_check("mid_d");
        check("mid.pre", 32'(hold_pc), 1);
        #2 reset = 1'b1;
        #1;
        check("mid.hold_pc", 32'(hold_pc),      0);
        check("mid.bubble",  32'(bubble_id_ex), 0);
        check("mid.count",   32'(stall_count),  0);
        check("mid.s_count", 32'(s_stall_count), 0);
        fl.delete();
        m_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Random traffic on a small register set to provoke hazards
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 99) < 8));
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_hazard_scoreboard.md
# mips_hazard_scoreboard

Parametrised hazard and redirect controller for the 5-stage MIPS pipeline. It tracks the destination register of every instruction in flight past ID using a shift-register scoreboard, and generates stall and flush controls for the IF/ID and ID/EX pipeline registers. It replaces the current uncontrolled pipeline, in which nothing stalls or flushes, and sits between the ID stage outputs and the pipeline-register enables. Optional forwarding selects drive the EX-stage operand muxes.

## Interface
Parameters:
- NUM_STAGES, 3: stages tracked after ID (1 = EX, 2 = MEM, 3 = WB); legal range 2..6.
- REG_ADDR_W, 5: register address width.
- WB_BYPASS, 0: 1 means the register file is write-first, so entry NUM_STAGES is never a hazard.
- REDIRECT_STAGE, 3: scoreboard index of the stage that asserts redirect; legal range 1..NUM_STAGES.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs / id_rt  in  REG_ADDR_W  source register addresses.
- id_rs_used / id_rt_used  in  1  source is actually read.
- id_dest  in  REG_ADDR_W  destination register.
- id_reg_write  in  1  instruction writes the register file.
- id_mem_read  in  1  instruction is a load.
- redirect  in  1  branch, jump or jr taken in REDIRECT_STAGE.
- hold_pc  out  1  PC keeps its value.
- hold_if_id  out  1  IF/ID register keeps its value.
- bubble_id_ex  out  1  ID/EX loads a NOP with all controls 0.
- flush  out  NUM_STAGES+1  bit k clears the pipeline register feeding stage k; bit 0 is IF/ID.
- fwd_rs_sel / fwd_rt_sel  out  $clog2(NUM_STAGES+1)  0 selects the register file; k selects the entry-k result.
- stall_count  out  CNT_W  saturating count of stall cycles.

## Operation
- Scoreboard entry k, for k = 1..NUM_STAGES, holds {valid, dest, load}. An entry is valid only when its instruction has reg_write set and dest ≠ 0.
- Match: a source matches entry k when the source is used, the entry is valid, and dest equals the source address. When WB_BYPASS = 1, entry NUM_STAGES is excluded from matching.
- Stall-only build (macro undefined): stall when any match exists. fwd_*_sel is held at 0.
- Forwarding build: for each source, select the smallest matching k. Stall only when that k = 1 and entry 1 is a load (load-use).
- While stalling: hold_pc = 1, hold_if_id = 1, bubble_id_ex = 1, and entry 1 loads invalid.
- Otherwise entry 1 loads the ID instruction if id_valid is set.
- Entries always shift k → k+1. Entry NUM_STAGES retires.
- Redirect has priority over stall:
  - flush bits 0..REDIRECT_STAGE-1 are set and the hold outputs are forced to 0.
  - entries 1..REDIRECT_STAGE-1 load invalid at the next edge.
  - the redirecting entry shifts normally.
- stall_count increments on each stall cycle that is not overridden by redirect. It saturates at all-ones.

## Timing
- All outputs are combinational from scoreboard state and ID inputs, so there is zero-cycle latency to the enables. State updates on the rising clk edge.
- Reset state: all entries invalid, stall_count = 0. Consequently, with id_valid = 0, every output is 0.
- Reset asserted mid-stall: the scoreboard clears immediately and the stall drops in the same cycle.
- id_valid = 0: no stall is raised, and a bubble enters entry 1.
- Stall length for a back-to-back dependency in the stall-only build: NUM_STAGES cycles when WB_BYPASS = 0, NUM_STAGES−1 cycles when WB_BYPASS = 1.

## Configuration
- HAZARD_FWD_EN defined: forwarding is enabled, stalls are limited to load-use, and fwd_*_sel outputs are live.
- HAZARD_FWD_EN undefined: no forwarding logic is built, fwd_*_sel is tied to 0, and every RAW hazard stalls.

## Structure
- Package mips_pipe_pkg holds:
  - constants STAGE_EX = 1, STAGE_MEM = 2, STAGE_WB = 3.
  - typedef sb_entry_t {valid, dest, load}.
  - the function for the fwd select width.
- Sub-module hazard_match is instantiated once per source. It compares one source against all entries and returns the match vector and the nearest index.

## Test plan
- Stall-only build, defaults: `add $1` followed by `add $2,$1,$1` → hold_pc = 1 for exactly 3 cycles; stall_count = 3.
- Forwarding build: the same pair → no stall; fwd_rs_sel = fwd_rt_sel = 1 while the add is in ID. On the next dependent instruction, the select is 2.
- Forwarding build: `lw $1` followed by `add $3,$1,$0` → 1 stall cycle with bubble_id_ex = 1, then fwd_rs_sel = 2.
- Write to $0 followed by an instruction reading $0 → no stall, fwd_*_sel = 0.
- Redirect pulsed in WB while ID is stalled → flush = 4'b0111, hold_pc = 0; on the next cycle, entries 1..2 are invalid.
- Reset asserted mid-stall → outputs 0 asynchronously. Separately, force stall_count to 0xFFFF, then stall again → stall_count stays at 0xFFFF.
